// File: rtl/qmac_accum.sv
// qmac_accum: streaming dot-product accumulator with guard bits, N-bit saturation and a registered result stage.
// Optional macro QMAC_BIAS_EN adds a bias port whose value seeds the accumulator for every vector.
module qmac_accum #(
  parameter int N = 16,
  parameter int Q = 12,
  parameter int G = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_ovf,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf
`ifdef QMAC_BIAS_EN
  ,
  input  logic [N-1:0] bias
`endif
);
  localparam int W = N + G;
  if (Q > N - 1) begin : g_q_chk
    $error("Q must leave room for the sign bit");
  end
  typedef enum logic {ACC, HOLD} state_t;
  state_t state_q;
  logic [W-1:0] acc_q, acc_d, acc_init;
  logic [W:0] sum_w;
  logic [N-1:0] out_data_q, res;
  logic ovf_q, out_valid_q, out_ovf_q, clamp, sat, fire;
`ifdef QMAC_BIAS_EN
  assign acc_init = {{G{bias[N-1]}}, bias};
`else
  assign acc_init = '0;
`endif
  assign in_ready  = state_q == ACC;
  assign fire      = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  // One extra bit exposes guard overflow; clamp back into the W-bit range.
  assign sum_w = {acc_q[W-1], acc_q} + {{(G+1){in_data[N-1]}}, in_data};
  assign clamp = sum_w[W] ^ sum_w[W-1];
  assign acc_d = clamp ? {sum_w[W], {(W-1){~sum_w[W]}}} : sum_w[W-1:0];
  assign sat   = acc_d[W-1:N-1] != {(G+1){acc_d[W-1]}};
  assign res   = sat ? {acc_d[W-1], {(N-1){~acc_d[W-1]}}} : acc_d[N-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= acc_init;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q     <= ACC;
      acc_q       <= acc_init;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (fire && !in_last) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | in_ovf | clamp;
      end
      if (fire && in_last) begin
        out_data_q  <= res;
        out_ovf_q   <= ovf_q | in_ovf | clamp | sat;
        out_valid_q <= 1'b1;
        state_q     <= HOLD;
        acc_q       <= acc_init;
        ovf_q       <= 1'b0;
      end
      if (state_q == HOLD && out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= ACC;
      end
    end
  end
endmodule

// File: tb/tb_qmac_accum.sv
// tb_qmac_accum: directed self-checking bench for qmac_accum (bias scenario only when QMAC_BIAS_EN is defined).
module tb_qmac_accum;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic in_valid = 1'b0, in_ovf = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_ovf;
  logic [15:0] out_data;
  int tests = 0, fails = 0;
`ifdef QMAC_BIAS_EN
  logic [15:0] bias = '0;
`endif
  qmac_accum dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ovf(in_ovf), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
`ifdef QMAC_BIAS_EN
    , .bias(bias)
`endif
  );
  always #5 clk = ~clk;
  task automatic beat(input logic [15:0] d, input logic o, input logic l);
    in_valid = 1'b1; in_data = d; in_ovf = o; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_ovf = 1'b0; in_last = 1'b0;
  endtask
  task automatic pop;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_basic(input logic [15:0] exp);
    beat(16'h1000, 1'b0, 1'b0);
    beat(16'h0800, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'hF000; in_last = 1'b1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", out_valid); end
    tests++; if (out_data !== exp) begin fails++; $display("FAIL basic_data got %h want %h", out_data, exp); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_hold_ready got %b want 0", in_ready); end
    pop();
  endtask
  task automatic test_saturate;
    for (int i = 0; i < 7; i++) beat(16'h7000, 1'b0, 1'b0);
    beat(16'h7000, 1'b0, 1'b1);
    tests++; if (out_data !== 16'h7FFF) begin fails++; $display("FAIL sat_pos_data got %h want 7fff", out_data); end
    tests++; if (out_ovf !== 1'b1) begin fails++; $display("FAIL sat_pos_ovf got %b want 1", out_ovf); end
    pop();
    for (int i = 0; i < 3; i++) beat(16'h9000, 1'b0, 1'b0);
    beat(16'h9000, 1'b0, 1'b1);
    tests++; if (out_data !== 16'h8000) begin fails++; $display("FAIL sat_neg_data got %h want 8000", out_data); end
    tests++; if (out_ovf !== 1'b1) begin fails++; $display("FAIL sat_neg_ovf got %b want 1", out_ovf); end
    pop();
  endtask
  task automatic test_guard;
    beat(16'h7000, 1'b0, 1'b0); beat(16'h7000, 1'b0, 1'b0);
    beat(16'h9000, 1'b0, 1'b0); beat(16'h9000, 1'b0, 1'b1);
    tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL guard_data got %h want 0000", out_data); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL guard_ovf got %b want 0", out_ovf); end
    pop();
    beat(16'h7000, 1'b0, 1'b0); beat(16'h7000, 1'b1, 1'b0);
    beat(16'h9000, 1'b0, 1'b0); beat(16'h9000, 1'b0, 1'b1);
    tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL guard_in_ovf_data got %h want 0000", out_data); end
    tests++; if (out_ovf !== 1'b1) begin fails++; $display("FAIL guard_in_ovf_flag got %b want 1", out_ovf); end
    pop();
  endtask
  task automatic test_backpressure;
    beat(16'h1000, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 16'h0400; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (out_data !== 16'h1000 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_%0d data %h valid %b want 1000 1", i, out_data, out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_pop_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_pop_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
    tests++; if (out_data !== 16'h0400) begin fails++; $display("FAIL bp_next_data got %h want 0400", out_data); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL bp_next_ovf got %b want 0", out_ovf); end
    pop();
  endtask
  task automatic test_rst_mid;
    beat(16'h1000, 1'b1, 1'b0); beat(16'h0800, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_ovf !== 1'b0) begin fails++; $display("FAIL rst_mid_out got %b %h %b want 0 0000 0", out_valid, out_data, out_ovf); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    beat(16'h0C00, 1'b0, 1'b1);
    tests++; if (out_data !== 16'h0C00 || out_ovf !== 1'b0) begin fails++; $display("FAIL rst_fresh got %h %b want 0c00 0", out_data, out_ovf); end
    pop();
  endtask
  task automatic test_clr_mid;
    beat(16'h1000, 1'b1, 1'b0); beat(16'h0800, 1'b0, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h0400; in_last = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin fails++; $display("FAIL clr_mid_out got %b %h %b want 0 0000 1", out_valid, out_data, in_ready); end
    beat(16'h0C00, 1'b0, 1'b1);
    tests++; if (out_data !== 16'h0C00 || out_ovf !== 1'b0) begin fails++; $display("FAIL clr_fresh got %h %b want 0c00 0", out_data, out_ovf); end
    pop();
  endtask
`ifdef QMAC_BIAS_EN
  task automatic test_bias;
    bias = 16'h0400; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    test_basic(16'h0C00);
    bias = 16'h0000; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_basic(16'h0800);
    test_saturate();
    test_guard();
    test_backpressure();
    test_rst_mid();
    test_clr_mid();
`ifdef QMAC_BIAS_EN
    test_bias();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qmac_accum.md
Name: qmac_accum

Overview:
- Streaming dot-product accumulator. Sits directly downstream of the Q-format fixed-point multiplier.
- Consumes one signed product per accepted beat and sums the products of one vector in a guard-extended accumulator.
- On the last term of a vector, produces one saturated N-bit pre-activation value with an overflow flag for the GRU/LSTM gate activation stage.
- Output side is a single-entry registered valid/ready stage.

Parameters:
- N, 16, total word width of products and result (1 sign + integer + fraction bits)
- Q, 12, fractional bits; products and result share the same binary point
- G, 8, accumulator guard bits; internal accumulator width is N+G

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous clear; discards partial sum and any held output
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a product beat
- in_data  input  N  signed two's-complement product, Q fractional bits
- in_ovf  input  1  overflow flag from the multiplier for this product
- in_last  input  1  beat is the final term of the vector
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  N  saturated signed result, Q fractional bits
- out_ovf  output  1  any overflow or saturation occurred in this vector

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = ACC
  - acc = 0 (or the bias value when the optional feature is compiled in; see below)
  - ovf_sticky = 0
  - out_valid = 0, out_data = 0, out_ovf = 0
- States:
  - ACC: in_ready = 1.
  - HOLD: in_ready = 0.
- Transfer: occurs on a rising edge with in_valid & in_ready.
- ACC, transfer with in_last = 0:
  - acc <= acc + sign_extend(in_data), computed at N+G+1 bits and clamped to the (N+G)-bit signed range.
  - If that clamp engages, or in_ovf = 1, ovf_sticky <= 1.
  - Stay in ACC.
- ACC, transfer with in_last = 1:
  - Compute sum = clamp(acc + sign_extend(in_data)).
  - out_data <= sum saturated to N bits: max 0x7FF..F, min 0x80..0.
  - out_ovf <= ovf_sticky | in_ovf | guard clamp | N-bit saturation.
  - out_valid <= 1; state <= HOLD.
  - acc and ovf_sticky return to their reset values.
- Latency: out_valid asserts the cycle after the last-beat transfer. A single-beat vector (in_last on the first beat) is legal.
- HOLD:
  - out_data and out_ovf are stable while out_valid = 1 and out_ready = 0.
  - When out_valid & out_ready: out_valid <= 0 and state <= ACC; in_ready = 1 on the following cycle.
- Throughput: an L-term vector occupies at least L+1 cycles.
- in_valid while in HOLD: the beat is not consumed. The upstream stage holds in_data, in_ovf and in_last stable until in_ready.
- in_ovf, in_last and in_data are ignored when no transfer occurs.
- clr (synchronous, priority over all else except rst):
  - acc and ovf_sticky return to reset values.
  - out_valid <= 0; state <= ACC.
  - Any in-flight beat in that cycle is dropped.
- rst mid-vector or mid-HOLD: all state returns to reset values immediately and the partial sum is lost.
- Intermediate sums may exceed the N-bit range without error. Only the final N-bit saturation and the guard clamp set the flag.

Optional Feature:
- Macro: QMAC_BIAS_EN.
- When defined:
  - Adds input port bias (N bits, signed, Q fractional).
  - At reset, at clr, and after each last-beat transfer, acc loads sign_extend(bias) instead of 0, so every vector result includes the bias.
  - bias is sampled at those load points only.
- When undefined: no bias port; acc starts at 0.

Test Plan:
- Terms 0x1000, 0x0800, 0xF000 (+1.0, +0.5, -1.0), last on the third -> out_data 0x0800, out_ovf 0, out_valid one cycle after the third transfer.
- Eight terms of 0x7000 (+7.0) -> sum 56.0 saturates -> out_data 0x7FFF, out_ovf 1. Four terms of 0x9000 (-7.0) -> out_data 0x8000, out_ovf 1.
- Terms 0x7000, 0x7000, 0x9000, 0x9000 -> intermediate +14.0 is absorbed by the guard bits -> out_data 0x0000, out_ovf 0. Repeat with in_ovf = 1 on the second beat -> out_data 0x0000, out_ovf 1.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles after out_valid: out_data is stable and in_ready = 0 with in_valid held high.
  - Then raise out_ready: in_ready = 1 on the next cycle.
  - The next vector (single beat 0x0400, last) -> 0x0400 with out_ovf 0, confirming acc was cleared.
- Assert rst (and separately clr) after 2 of 3 beats -> outputs zero. Then a fresh vector 0x0C00 (last) -> 0x0C00.
- With QMAC_BIAS_EN and bias = 0x0400, re-run the first scenario -> out_data 0x0C00.
